instr_loader: RTL and testbench

//  Boot-time program loader upstream of the CPU top. Receives a little-endian byte stream
//  (host/UART side) using valid/ready. Assembles 32-bit instructions and drives the CPU's

---
 rtl/instr_loader_if.sv | 25 ++
 rtl/instr_loader.sv | 151 +++++++++++++++
 tb/tb_instr_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-write signals between the host side and instr_loader.
// The host/bench drives through master; the loader connects through slave.
interface instr_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              wr_instr_en_o;
  logic [31:0]       wr_instr_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              run_o;
  logic              err_o;

  modport master (
    output start_i, byte_valid_i, byte_i,
    input  byte_ready_o, wr_instr_en_o, wr_instr_o, wr_addr_o, run_o, err_o
  );

  modport slave (
    input  start_i, byte_valid_i, byte_i,
    output byte_ready_o, wr_instr_en_o, wr_instr_o, wr_addr_o, run_o, err_o
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time loader: parses a 16-bit LE word count, then assembles LE bytes into
// 32-bit instructions and strobes each one into CPU instruction memory.
module instr_loader #(
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ADDR_W         = $clog2(MAX_WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  instr_loader_if.slave   bus
);

  localparam int              GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     MAX_CNT  = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wr_instr_q, wr_instr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

  logic        ready;
  logic        accept;
  logic [15:0] cnt_new;
  logic        last_word;

  assign ready     = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) || (state_q == S_LOAD);
  assign accept    = ready && bus.byte_valid_i;
  assign cnt_new   = {bus.byte_i, cnt_q[7:0]};
  // word_idx is one bit wider than the address so a full MAX_WORDS load cannot wrap
  assign last_word = ((16'(word_idx_q) + 16'd1) == cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    gap_d      = gap_q;
    wr_en_d    = 1'b0;
    wr_instr_d = wr_instr_q;
    wr_addr_d  = wr_addr_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        gap_d = '0;
        if (bus.start_i) state_d = S_CNT_LO;
      end

      S_CNT_LO: begin
        gap_d = '0;
        if (accept) begin
          cnt_d[7:0] = bus.byte_i;
          state_d    = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = bus.byte_i;
          gap_d       = '0;
          if (cnt_new == 16'd0) begin
            state_d = S_DONE;
          end else if (cnt_new > MAX_CNT) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_LOAD;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = S_ERR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_LOAD: begin
        if (accept) begin
          gap_d      = '0;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = bus.byte_i;
            2'd1: asm_d[15:8]  = bus.byte_i;
            2'd2: asm_d[23:16] = bus.byte_i;
            default: begin
              wr_en_d    = 1'b1;
              wr_instr_d = {bus.byte_i, asm_q};
              wr_addr_d  = word_idx_q[ADDR_W-1:0];
              word_idx_d = word_idx_q + 1'b1;
              if (last_word) state_d = S_DONE;
            end
          endcase
        end else if (gap_q == GAP_LAST) begin
          // a stalled partial word is simply abandoned; nothing is strobed
          state_d = S_ERR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      asm_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      gap_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_instr_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      gap_q      <= gap_d;
      wr_en_q    <= wr_en_d;
      wr_instr_q <= wr_instr_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign bus.byte_ready_o  = ready;
  assign bus.wr_instr_en_o = wr_en_q;
  assign bus.wr_instr_o    = wr_instr_q;
  assign bus.wr_addr_o     = wr_addr_q;
  assign bus.run_o         = (state_q == S_DONE);
  assign bus.err_o         = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected strobes are queued as words are sent
// and checked by a monitor when the loader writes them.
module tb_instr_loader;
  localparam int MAXW = 1024;
  localparam int TMO  = 200;
  localparam int AW   = $clog2(MAXW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   strobes    = 0;
  logic [AW+31:0] expq[$];

  instr_loader_if #(.ADDR_W(AW)) bus();

  instr_loader #(
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // strobe monitor: every write must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && bus.wr_instr_en_o === 1'b1) begin
      logic [AW+31:0] e;
      strobes++;
      compared++;
      if (expq.size() == 0) begin
        mismatched++;
        $display("FAIL strobe_unexpected: got addr %0d data %h, need no strobe",
                 bus.wr_addr_o, bus.wr_instr_o);
      end else begin
        e = expq.pop_front();
        if ({bus.wr_addr_o, bus.wr_instr_o} !== e)
          begin
            mismatched++;
            $display("FAIL strobe: got addr %0d data %h, need addr %0d data %h",
                     bus.wr_addr_o, bus.wr_instr_o, e[AW+31:32], e[31:0]);
          end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    @(negedge clk);
    while (bus.byte_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.byte_ready_o !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL send_byte_ready: got %b, need 1 within 20 cycles", bus.byte_ready_o);
    end
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_count(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d, input int max_gap);
    expq.push_back({a, d});
    for (int i = 0; i < 4; i++) begin
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
      send_byte(d[8*i +: 8]);
    end
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    rst              = 1'b1;
    idle(3);
    @(negedge clk);
    compared++;
    if ({bus.byte_ready_o, bus.wr_instr_en_o, bus.wr_instr_o, bus.wr_addr_o,
         bus.run_o, bus.err_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b en=%b instr=%h addr=%0d run=%b err=%b, need all 0",
               bus.byte_ready_o, bus.wr_instr_en_o, bus.wr_instr_o, bus.wr_addr_o,
               bus.run_o, bus.err_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s0 = strobes;
    // start together with a valid byte in IDLE: the byte must not be taken
    bus.start_i      = 1'b1;
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'h55;
    @(negedge clk);
    compared++;
    if (bus.byte_ready_o !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_ready: got %b, need 0", bus.byte_ready_o);
    end
    @(posedge clk);
    #1;
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b0;
    send_count(16'd2);
    send_word(AW'(0), 32'h0000_0013, 0);
    do_start();  // ignored mid-load
    send_word(AW'(1), 32'h0010_0093, 0);
    compared++;
    if (bus.run_o !== 1'b1 || bus.err_o !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_run: got run=%b err=%b, need run=1 err=0", bus.run_o, bus.err_o);
    end
    idle(3);
    compared++;
    if (strobes - s0 != 2 || expq.size() != 0) begin
      mismatched++;
      $display("FAIL basic_count: got %0d strobes (%0d pending), need 2 (0)",
               strobes - s0, expq.size());
    end
    compared++;
    if (bus.wr_addr_o !== AW'(1) || bus.wr_instr_o !== 32'h0010_0093) begin
      mismatched++;
      $display("FAIL basic_hold: got addr %0d data %h, need addr 1 data 00100093",
               bus.wr_addr_o, bus.wr_instr_o);
    end
  endtask

  task automatic test_zero_count();
    int s0 = strobes;
    do_start();
    send_count(16'd0);
    compared++;
    if (bus.run_o !== 1'b1 || bus.err_o !== 1'b0 || bus.byte_ready_o !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_done: got run=%b err=%b rdy=%b, need run=1 err=0 rdy=0",
               bus.run_o, bus.err_o, bus.byte_ready_o);
    end
    idle(3);
    compared++;
    if (strobes != s0) begin
      mismatched++;
      $display("FAIL zero_strobes: got %0d, need 0", strobes - s0);
    end
  endtask

  task automatic test_oversize();
    int s0 = strobes;
    do_start();
    compared++;
    if (bus.run_o !== 1'b0 || bus.byte_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_from_done: got run=%b rdy=%b, need run=0 rdy=1",
               bus.run_o, bus.byte_ready_o);
    end
    send_count(16'(MAXW + 1));
    idle(5);
    compared++;
    if (bus.err_o !== 1'b1 || bus.byte_ready_o !== 1'b0 || strobes != s0) begin
      mismatched++;
      $display("FAIL oversize_err: got err=%b rdy=%b strobes=%0d, need err=1 rdy=0 strobes=0",
               bus.err_o, bus.byte_ready_o, strobes - s0);
    end
    do_start();
    compared++;
    if (bus.err_o !== 1'b0 || bus.byte_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL oversize_restart: got err=%b rdy=%b, need err=0 rdy=1",
               bus.err_o, bus.byte_ready_o);
    end
  endtask

  task automatic test_timeout();
    int s0 = strobes;
    send_count(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(TMO - 1);
    compared++;
    if (bus.err_o !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_early: got err=%b after %0d idle cycles, need 0", bus.err_o, TMO - 1);
    end
    idle(1);
    compared++;
    if (bus.err_o !== 1'b1 || bus.byte_ready_o !== 1'b0 || strobes != s0) begin
      mismatched++;
      $display("FAIL timeout_hit: got err=%b rdy=%b strobes=%0d, need err=1 rdy=0 strobes=0",
               bus.err_o, bus.byte_ready_o, strobes - s0);
    end
    // last byte lands in the final allowed idle cycle
    do_start();
    send_count(16'd1);
    expq.push_back({AW'(0), 32'h4433_2211});
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(TMO - 1);
    send_byte(8'h44);
    compared++;
    if (bus.err_o !== 1'b0 || bus.run_o !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_edge: got err=%b run=%b, need err=0 run=1", bus.err_o, bus.run_o);
    end
    idle(2);
    compared++;
    if (strobes - s0 != 1 || expq.size() != 0) begin
      mismatched++;
      $display("FAIL timeout_edge_strobes: got %0d, need 1", strobes - s0);
    end
  endtask

  task automatic test_async_reset();
    int s0;
    do_start();
    send_count(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #3;
    rst = 1'b1;
    #1;
    compared++;
    if ({bus.byte_ready_o, bus.wr_instr_en_o, bus.wr_instr_o, bus.wr_addr_o,
         bus.run_o, bus.err_o} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got rdy=%b instr=%h run=%b err=%b, need all 0",
               bus.byte_ready_o, bus.wr_instr_o, bus.run_o, bus.err_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = strobes;
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'hCC;
    idle(3);
    bus.byte_valid_i = 1'b0;
    compared++;
    if (bus.byte_ready_o !== 1'b0 || strobes != s0) begin
      mismatched++;
      $display("FAIL post_reset_idle: got rdy=%b strobes=%0d, need rdy=0 strobes=0",
               bus.byte_ready_o, strobes - s0);
    end
    do_start();
    send_count(16'd1);
    send_word(AW'(0), 32'hCAFE_F00D, 0);
    idle(2);
    compared++;
    if (strobes - s0 != 1 || expq.size() != 0 || bus.run_o !== 1'b1) begin
      mismatched++;
      $display("FAIL reload: got %0d strobes run=%b, need 1 strobe run=1", strobes - s0, bus.run_o);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = strobes;
    do_start();
    send_count(16'(MAXW));
    for (int i = 0; i < MAXW; i++) send_word(AW'(i), $urandom, 3);
    compared++;
    if (bus.run_o !== 1'b1 || bus.err_o !== 1'b0) begin
      mismatched++;
      $display("FAIL full_run: got run=%b err=%b, need run=1 err=0", bus.run_o, bus.err_o);
    end
    idle(2);
    compared++;
    if (strobes - s0 != MAXW || expq.size() != 0) begin
      mismatched++;
      $display("FAIL full_count: got %0d strobes (%0d pending), need %0d (0)",
               strobes - s0, expq.size(), MAXW);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_oversize();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
